// File: rtl/sobel_frame_loader_if.sv
// rtl/sobel_frame_loader_if.sv - pixel stream and SRAM1 write bundle for sobel_frame_loader
// Purpose: groups the 8-bit pixel handshake and the SRAM1 word-write signals.
// Ports:
//   pix_data/pix_valid/pix_sof  pixel byte, valid, first-pixel-of-frame marker
//   pix_ready                   loader accepts the pixel this cycle
//   we1/write_addr1/data1       SRAM1 write enable, word address, packed 64-bit word
// Modports: master = loader side, slave = pixel source / SRAM side.
interface sobel_frame_loader_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic        we1;
  logic [19:0] write_addr1;
  logic [63:0] data1;

  modport master (
    input  pix_data, pix_valid, pix_sof,
    output pix_ready, we1, write_addr1, data1
  );

  modport slave (
    output pix_data, pix_valid, pix_sof,
    input  pix_ready, we1, write_addr1, data1
  );
endinterface

// File: rtl/sobel_frame_loader.sv
// rtl/sobel_frame_loader.sv - packs a pixel stream into 64-bit SRAM1 words for the Sobel block
// Purpose: accepts 8-bit pixels, packs 8 per word (first pixel in [63:56]), writes
//   FRAME_WORDS words starting at BASE_ADDR, then pulses startEn.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   getNext      refill request, rising edge starts a new fill from IDLE
//   pix          pixel stream in, SRAM1 write out (sobel_frame_loader_if.master)
//   startEn      one-cycle pulse when a full frame is resident
//   busy         high while waiting for start-of-frame or filling
//   sof_err      sticky: start-of-frame seen mid-frame
//   req_ovr      sticky: getNext edge while not idle
//   frame_cnt    completed frames, wrapping
module sobel_frame_loader #(
  parameter int FRAME_WORDS = 32768,
  parameter int BASE_ADDR   = 0,
  parameter int AUTO_START  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        getNext,
  sobel_frame_loader_if.master        pix,
  output logic                        startEn,
  output logic                        busy,
  output logic                        sof_err,
  output logic                        req_ovr,
  output logic [7:0]                  frame_cnt
);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, FILL, DONE} state_t;
  localparam state_t RST_STATE = (AUTO_START != 0) ? SYNC : IDLE;

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [63:0] pack_q, pack_d;
  logic        getnext_q, getnext_d;
  logic        pix_ready_q, pix_ready_d;
  logic        we1_q, we1_d;
  logic [19:0] write_addr1_q, write_addr1_d;
  logic [63:0] data1_q, data1_d;
  logic        start_en_q, start_en_d;
  logic        busy_q, busy_d;
  logic        sof_err_q, sof_err_d;
  logic        req_ovr_q, req_ovr_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        accept;
  logic        req_edge;
  logic [63:0] shifted;

  assign accept   = pix.pix_valid & pix_ready_q;
  assign req_edge = getNext & ~getnext_q;
  assign shifted  = {pack_q[55:0], pix.pix_data};

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_cnt_d    = word_cnt_q;
    pack_d        = pack_q;
    getnext_d     = getNext;
    we1_d         = 1'b0;
    write_addr1_d = write_addr1_q;
    data1_d       = data1_q;
    start_en_d    = 1'b0;
    sof_err_d     = sof_err_q;
    req_ovr_d     = req_ovr_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_edge) state_d = SYNC;
      end
      SYNC: begin
        // Bytes before the first start-of-frame are dropped on the floor.
        if (accept && pix.pix_sof) begin
          pack_d     = shifted;
          byte_cnt_d = 3'd1;
          word_cnt_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          pack_d = shifted;
          if (pix.pix_sof && (byte_cnt_q != 3'd0 || word_cnt_q != '0)) begin
            // Resync: restart the frame at word 0, overwriting what was written.
            sof_err_d  = 1'b1;
            byte_cnt_d = 3'd1;
            word_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
              we1_d         = 1'b1;
              data1_d       = shifted;
              write_addr1_d = 20'(BASE_ADDR) + 20'(word_cnt_q);
              if (word_cnt_q == WCW'(FRAME_WORDS - 1)) begin
                word_cnt_d = '0;
                state_d    = DONE;
              end else begin
                word_cnt_d = word_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        start_en_d  = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = IDLE;
      end
      default: state_d = RST_STATE;
    endcase

    // Requests are not queued: any edge outside IDLE is only flagged.
    if (req_edge && state_q != IDLE) req_ovr_d = 1'b1;

    pix_ready_d = (state_d == SYNC) || (state_d == FILL);
    busy_d      = pix_ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RST_STATE;
      byte_cnt_q    <= '0;
      word_cnt_q    <= '0;
      pack_q        <= '0;
      getnext_q     <= 1'b0;
      pix_ready_q   <= 1'b0;
      we1_q         <= 1'b0;
      write_addr1_q <= '0;
      data1_q       <= '0;
      start_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      sof_err_q     <= 1'b0;
      req_ovr_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_cnt_q    <= word_cnt_d;
      pack_q        <= pack_d;
      getnext_q     <= getnext_d;
      pix_ready_q   <= pix_ready_d;
      we1_q         <= we1_d;
      write_addr1_q <= write_addr1_d;
      data1_q       <= data1_d;
      start_en_q    <= start_en_d;
      busy_q        <= busy_d;
      sof_err_q     <= sof_err_d;
      req_ovr_q     <= req_ovr_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix.pix_ready   = pix_ready_q;
  assign pix.we1         = we1_q;
  assign pix.write_addr1 = write_addr1_q;
  assign pix.data1       = data1_q;
  assign startEn         = start_en_q;
  assign busy            = busy_q;
  assign sof_err         = sof_err_q;
  assign req_ovr         = req_ovr_q;
  assign frame_cnt       = frame_cnt_q;
endmodule

// File: tb/tb_sobel_frame_loader.sv
// tb/tb_sobel_frame_loader.sv - self-checking bench for sobel_frame_loader
module tb_sobel_frame_loader;
  localparam int FW = 4;
  localparam int BA = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       getNext = 1'b0;
  logic       startEn, busy, sof_err, req_ovr;
  logic [7:0] frame_cnt;

  sobel_frame_loader_if bus();

  sobel_frame_loader #(.FRAME_WORDS(FW), .BASE_ADDR(BA), .AUTO_START(1)) dut (
    .clk(clk), .reset(reset), .getNext(getNext), .pix(bus),
    .startEn(startEn), .busy(busy), .sof_err(sof_err), .req_ovr(req_ovr),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [19:0] g_addr[$];
  logic [63:0] g_data[$];
  int          g_cyc[$];
  int          s_cyc[$];

  always @(negedge clk) begin
    if (bus.we1 === 1'b1) begin
      g_addr.push_back(bus.write_addr1);
      g_data.push_back(bus.data1);
      g_cyc.push_back(cyc);
    end
    if (startEn === 1'b1) s_cyc.push_back(cyc);
  end

  logic [7:0] acc_b[$];
  bit         acc_s[$];
  int         acc_c[$];
  int         stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, input bit s);
    int tries;
    bit done;
    tries = 0;
    done  = 0;
    bus.pix_data  = b;
    bus.pix_sof   = s;
    bus.pix_valid = 1'b1;
    while (!done && tries < 50) begin
      if (bus.pix_ready === 1'b1) begin
        acc_b.push_back(b);
        acc_s.push_back(s);
        acc_c.push_back(cyc);
        done = 1;
      end else begin
        stalls++;
      end
      tries++;
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_seg();
    g_addr.delete(); g_data.delete(); g_cyc.delete(); s_cyc.delete();
    acc_b.delete(); acc_s.delete(); acc_c.delete();
    stalls = 0;
  endtask

  task automatic do_reset(input string t);
    reset   = 1'b1;
    getNext = 1'b0;
    idle(3);
    chk({t, "_rst_we1"},   bus.we1, 1'b0);
    chk({t, "_rst_addr"},  bus.write_addr1, 20'd0);
    chk({t, "_rst_data"},  bus.data1, 64'd0);
    chk({t, "_rst_ready"}, bus.pix_ready, 1'b0);
    chk({t, "_rst_start"}, startEn, 1'b0);
    chk({t, "_rst_busy"},  busy, 1'b0);
    chk({t, "_rst_soferr"}, sof_err, 1'b0);
    chk({t, "_rst_reqovr"}, req_ovr, 1'b0);
    chk({t, "_rst_fcnt"},  frame_cnt, 8'd0);
    clear_seg();
    reset = 1'b0;
    idle(2);
  endtask

  // Reference: the accepted byte list is replayed as a frame buffer. A start
  // marker begins (or restarts) the frame; every 8th byte of the frame buffer
  // produces word (len/8-1); a full buffer completes the frame.
  task automatic model_check(input string t, output bit e_err);
    logic [7:0]  fb[$];
    bit          started;
    logic [63:0] w;
    int          nw, nf, len;
    started = 0;
    nw = 0;
    nf = 0;
    e_err = 0;
    for (int i = 0; i < acc_b.size(); i++) begin
      if (!started) begin
        if (acc_s[i]) begin
          started = 1;
          fb.delete();
          fb.push_back(acc_b[i]);
        end
      end else if (acc_s[i]) begin
        e_err = 1;
        fb.delete();
        fb.push_back(acc_b[i]);
      end else begin
        fb.push_back(acc_b[i]);
        len = fb.size();
        if (len % 8 == 0) begin
          w = '0;
          for (int k = 0; k < 8; k++) w = {w[55:0], fb[len - 8 + k]};
          if (nw < g_addr.size()) begin
            chk($sformatf("%s_addr%0d", t, nw), g_addr[nw], 20'(BA + len / 8 - 1));
            chk($sformatf("%s_data%0d", t, nw), g_data[nw], w);
            chk($sformatf("%s_lat%0d", t, nw), g_cyc[nw], acc_c[i] + 1);
          end
          nw++;
          if (len == 8 * FW) begin
            if (nf < s_cyc.size())
              chk($sformatf("%s_start_lat%0d", t, nf), s_cyc[nf], acc_c[i] + 2);
            nf++;
            started = 0;
          end
        end
      end
    end
    chk({t, "_nwr"}, g_addr.size(), nw);
    chk({t, "_nstart"}, s_cyc.size(), nf);
  endtask

  bit   e_err;
  logic [7:0] rb;

  initial begin
    bus.pix_data  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    @(negedge clk);

    // T1: straight frame
    do_reset("t1");
    chk("t1_busy_sync", busy, 1'b1);
    for (int i = 0; i < 32; i++) push(8'(i), i == 0);
    idle(6);
    model_check("t1", e_err);
    chk("t1_word0", (g_data.size() > 0) ? g_data[0] : 64'hx, 64'h0001020304050607);
    chk("t1_word3", (g_data.size() > 3) ? g_data[3] : 64'hx, 64'h18191A1B1C1D1E1F);
    chk("t1_fcnt", frame_cnt, 8'd1);
    chk("t1_stalls", stalls, 0);
    chk("t1_ready_end", bus.pix_ready, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_soferr", sof_err, 1'b0);

    // T2: leading bytes without start marker are discarded
    do_reset("t2");
    push(8'hA5, 0); push(8'h5A, 0); push(8'h3C, 0);
    for (int i = 0; i < 32; i++) push(8'(i), i == 0);
    idle(6);
    model_check("t2", e_err);
    chk("t2_word0", (g_data.size() > 0) ? g_data[0] : 64'hx, 64'h0001020304050607);
    chk("t2_fcnt", frame_cnt, 8'd1);

    // T3: valid toggling every cycle
    do_reset("t3");
    for (int i = 0; i < 32; i++) begin
      push(8'(i), i == 0);
      idle(1);
    end
    idle(6);
    model_check("t3", e_err);
    chk("t3_stalls", stalls, 0);
    chk("t3_spacing", (g_cyc.size() > 1) ? g_cyc[1] - g_cyc[0] : -1, 16);

    // T4: start marker re-asserted on byte 12
    do_reset("t4");
    for (int i = 0; i < 12; i++) push(8'(i), i == 0);
    for (int i = 0; i < 32; i++) push(8'(8'h0C + i), i == 0);
    idle(6);
    model_check("t4", e_err);
    chk("t4_soferr", sof_err, e_err);
    chk("t4_soferr_set", sof_err, 1'b1);
    chk("t4_rewrite_addr", (g_addr.size() > 1) ? g_addr[1] : 20'hx, 20'd16);
    chk("t4_rewrite_data", (g_data.size() > 1) ? g_data[1] : 64'hx, 64'h0C0D0E0F10111213);

    // T5: getNext during FILL flagged, getNext in IDLE starts a second frame
    do_reset("t5");
    for (int i = 0; i < 10; i++) push(8'(i), i == 0);
    getNext = 1'b1; idle(1); getNext = 1'b0;
    for (int i = 10; i < 32; i++) push(8'(i), 0);
    idle(6);
    model_check("t5a", e_err);
    chk("t5_reqovr", req_ovr, 1'b1);
    chk("t5_fcnt1", frame_cnt, 8'd1);
    chk("t5_idle_ready", bus.pix_ready, 1'b0);
    getNext = 1'b1; idle(1); getNext = 1'b0;
    idle(2);
    chk("t5_busy_sync", busy, 1'b1);
    clear_seg();
    for (int i = 0; i < 32; i++) begin
      rb = 8'($urandom_range(0, 255));
      push(rb, i == 0);
    end
    idle(6);
    model_check("t5b", e_err);
    chk("t5_fcnt2", frame_cnt, 8'd2);
    chk("t5_reqovr_sticky", req_ovr, 1'b1);

    // T6: reset after word 1 written abandons the frame
    do_reset("t6");
    for (int i = 0; i < 16; i++) push(8'(i), i == 0);
    idle(3);
    chk("t6_pre_wr", g_addr.size(), 2);
    do_reset("t6b");
    idle(20);
    chk("t6_no_we1", g_addr.size(), 0);
    chk("t6_no_start", s_cyc.size(), 0);
    for (int i = 0; i < 32; i++) push(8'(8'h40 + i), i == 0);
    idle(6);
    model_check("t6", e_err);
    chk("t6_fcnt", frame_cnt, 8'd1);

    // T7: random bytes and random valid gaps
    do_reset("t7");
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom_range(0, 255));
      push(rb, 0);
      idle($urandom_range(0, 2));
    end
    for (int i = 0; i < 32; i++) begin
      rb = 8'($urandom_range(0, 255));
      push(rb, i == 0);
      idle($urandom_range(0, 2));
    end
    idle(6);
    model_check("t7", e_err);
    chk("t7_soferr", sof_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
